// File: rtl/therm_onehot_ptr_if.sv
// Request/response bundle for therm_onehot_ptr.
//   alloc_therm / free_therm : thermometer request masks (lane 0 = bit 0)
//   alloc_ok / free_ok        : all-or-nothing acceptance, same cycle
//   bad_req                   : either request mask is not a thermometer
//   alloc_oh / free_oh        : per-lane one-hot slot selects, lane i at [i*N +: N]
//   head_oh / tail_oh         : registered one-hot oldest / next-to-allocate entry
//   last_alloc_oh             : registered slot of the topmost lane of the last accepted alloc
//   count / full / empty      : registered occupancy and its flags
interface therm_onehot_ptr_if #(
  parameter int N = 8,
  parameter int W = 4
);
  localparam int CW = $clog2(N) + 1;

  logic [W-1:0]   alloc_therm;
  logic [W-1:0]   free_therm;
  logic           alloc_ok;
  logic           free_ok;
  logic           bad_req;
  logic [W*N-1:0] alloc_oh;
  logic [W*N-1:0] free_oh;
  logic [N-1:0]   head_oh;
  logic [N-1:0]   tail_oh;
  logic [N-1:0]   last_alloc_oh;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  modport master (
    output alloc_therm, free_therm,
    input  alloc_ok, free_ok, bad_req, alloc_oh, free_oh,
    input  head_oh, tail_oh, last_alloc_oh, count, full, empty
  );

  modport slave (
    input  alloc_therm, free_therm,
    output alloc_ok, free_ok, bad_req, alloc_oh, free_oh,
    output head_oh, tail_oh, last_alloc_oh, count, full, empty
  );
endinterface

// File: rtl/therm_onehot_ptr.sv
// Circular-queue pointer unit: thermometer alloc/free requests in, one-hot
// per-lane slot selects out, one-hot head/tail pointers and occupancy kept.
//   clock : sole clock, posedge
//   reset : asynchronous, active-high
//   bus   : therm_onehot_ptr_if slave modport (requests, selects, state)

// One lane of the decoder: base pointer rotated left by the lane index,
// gated by the lane enable.
module therm_onehot_lane #(
  parameter int N    = 8,
  parameter int LANE = 0
) (
  input  logic [N-1:0] base,
  input  logic         en,
  output logic [N-1:0] sel
);
  localparam int SH = LANE % N;

  logic [N-1:0] rot;

  if (SH == 0) begin : g_norot
    assign rot = base;
  end else begin : g_rot
    assign rot = {base[N-1-SH:0], base[N-1:N-SH]};
  end

  assign sel = en ? rot : '0;
endmodule

module therm_onehot_ptr #(
  parameter int N = 8,
  parameter int W = 4
) (
  input logic             clock,
  input logic             reset,
  therm_onehot_ptr_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  // Rotate left by s mod N; x >> N shifts everything out when s == 0.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int s);
    int r;
    r = s % N;
    return (x << r) | (x >> (N - r));
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [W-1:0] t);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + CW'(t[i]);
    return c;
  endfunction

  logic [W-1:0]          a, f, a_top;
  logic                  a_valid, f_valid;
  logic [CW-1:0]         k_a, k_f, space, count_nxt;
  logic                  alloc_ok, free_ok;
  logic [W-1:0][N-1:0]   a_sel, f_sel;
  logic [N-1:0]          last_nxt;

  logic [N-1:0]          head, tail, last;
  logic [CW-1:0]         count;
  logic                  full, empty;

  assign a = bus.alloc_therm;
  assign f = bus.free_therm;

  // Contiguous-from-bit-0 test; an all-ones mask wraps to zero on +1.
  assign a_valid = ((a & (a + W'(1))) == '0);
  assign f_valid = ((f & (f + W'(1))) == '0);

  assign k_a   = popcnt(a);
  assign k_f   = popcnt(f);
  assign space = CW'(N) - count;

  // Acceptance uses start-of-cycle count only: a same-cycle free does not
  // make room and a same-cycle alloc does not add freeable entries.
  assign alloc_ok = a_valid && (k_a != '0) && (k_a <= space);
  assign free_ok  = f_valid && (k_f != '0) && (k_f <= count);

  // One-hot of the topmost requested lane.
  assign a_top = a & ~(a >> 1);

  for (genvar i = 0; i < W; i++) begin : g_lane
    therm_onehot_lane #(.N(N), .LANE(i)) u_alloc (
      .base (tail),
      .en   (alloc_ok & a[i]),
      .sel  (a_sel[i])
    );
    therm_onehot_lane #(.N(N), .LANE(i)) u_free (
      .base (head),
      .en   (free_ok & f[i]),
      .sel  (f_sel[i])
    );
  end

  always_comb begin
    last_nxt = '0;
    for (int i = 0; i < W; i++)
      if (a_top[i]) last_nxt = last_nxt | a_sel[i];
  end

  // Net result is always 0..N, so modular CW-bit arithmetic is exact.
  assign count_nxt = count + (alloc_ok ? k_a : '0) - (free_ok ? k_f : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= N'(1);
      tail  <= N'(1);
      last  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (alloc_ok) begin
        tail <= rotl(tail, int'(k_a));
        last <= last_nxt;
      end
      if (free_ok) head <= rotl(head, int'(k_f));
      count <= count_nxt;
      full  <= (count_nxt == CW'(N));
      empty <= (count_nxt == '0);
    end
  end

  assign bus.alloc_ok      = alloc_ok;
  assign bus.free_ok       = free_ok;
  assign bus.bad_req       = !a_valid || !f_valid;
  assign bus.alloc_oh      = a_sel;
  assign bus.free_oh       = f_sel;
  assign bus.head_oh       = head;
  assign bus.tail_oh       = tail;
  assign bus.last_alloc_oh = last;
  assign bus.count         = count;
  assign bus.full          = full;
  assign bus.empty         = empty;
endmodule

// File: tb/tb_therm_onehot_ptr.sv
// Directed bench for therm_onehot_ptr, N=8, W=4.
module tb_therm_onehot_ptr;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  therm_onehot_ptr_if #(.N(8), .W(4)) bus ();

  therm_onehot_ptr #(.N(8), .W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [3:0] a, input logic [3:0] f);
    bus.alloc_therm = a;
    bus.free_therm  = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic state(input string tag, input logic [7:0] head, input logic [7:0] tail,
                       input logic [3:0] cnt, input logic [7:0] last,
                       input logic full, input logic empty);
    chk({tag, ".head"},  bus.head_oh, head);
    chk({tag, ".tail"},  bus.tail_oh, tail);
    chk({tag, ".count"}, bus.count, cnt);
    chk({tag, ".last"},  bus.last_alloc_oh, last);
    chk({tag, ".full"},  bus.full, full);
    chk({tag, ".empty"}, bus.empty, empty);
  endtask

  task automatic comb(input string tag, input logic aok, input logic fok, input logic bad,
                      input logic [31:0] aoh, input logic [31:0] foh);
    chk({tag, ".alloc_ok"}, bus.alloc_ok, aok);
    chk({tag, ".free_ok"},  bus.free_ok, fok);
    chk({tag, ".bad_req"},  bus.bad_req, bad);
    chk({tag, ".alloc_oh"}, bus.alloc_oh, aoh);
    chk({tag, ".free_oh"},  bus.free_oh, foh);
  endtask

  // Pointers must stay exactly one-hot at all times out of reset.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      assert ($onehot(bus.head_oh) && $onehot(bus.tail_oh)) else begin
        errors++;
        $error("FAIL onehot observed head %0h tail %0h expected one-hot", bus.head_oh, bus.tail_oh);
      end
    end
  end

  initial begin
    bus.alloc_therm = '0;
    bus.free_therm  = '0;
    #12;
    state("rst", 8'h01, 8'h01, 4'd0, 8'h00, 1'b0, 1'b1);
    reset = 1'b0;

    // alloc 0111 from reset
    req(4'b0111, 4'b0000);
    comb("a3", 1'b1, 1'b0, 1'b0, 32'h00040201, 32'h0);
    tick();
    state("a3", 8'h01, 8'h08, 4'd3, 8'h04, 1'b0, 1'b0);

    // alloc 1111 crosses slot 7
    req(4'b1111, 4'b0000);
    comb("a4", 1'b1, 1'b0, 1'b0, 32'h40201008, 32'h0);
    tick();
    state("a4", 8'h01, 8'h80, 4'd7, 8'h40, 1'b0, 1'b0);

    // alloc 0001 fills the queue; tail wraps onto head
    req(4'b0001, 4'b0000);
    comb("a1", 1'b1, 1'b0, 1'b0, 32'h00000080, 32'h0);
    tick();
    state("full", 8'h01, 8'h01, 4'd8, 8'h80, 1'b1, 1'b0);

    // alloc when full: rejected, nothing moves, last holds
    req(4'b0001, 4'b0000);
    comb("afull", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    state("afull", 8'h01, 8'h01, 4'd8, 8'h80, 1'b1, 1'b0);

    // free 0111 from full
    req(4'b0000, 4'b0111);
    comb("f3", 1'b0, 1'b1, 1'b0, 32'h0, 32'h00040201);
    tick();
    state("f3", 8'h08, 8'h01, 4'd5, 8'h80, 1'b0, 1'b0);

    // alloc 0011 after wrap
    req(4'b0011, 4'b0000);
    comb("a2", 1'b1, 1'b0, 1'b0, 32'h00000201, 32'h0);
    tick();
    state("a2", 8'h08, 8'h04, 4'd7, 8'h02, 1'b0, 1'b0);

    // alloc 1111 needs 4 but only 1 free slot: all-or-nothing reject
    req(4'b1111, 4'b0000);
    comb("aover", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    req(4'b0001, 4'b0000);
    comb("a1b", 1'b1, 1'b0, 1'b0, 32'h00000004, 32'h0);
    tick();
    state("full2", 8'h08, 8'h08, 4'd8, 8'h04, 1'b1, 1'b0);

    // simultaneous at count 8: free accepted, alloc rejected
    req(4'b0001, 4'b0011);
    comb("sim", 1'b0, 1'b1, 1'b0, 32'h0, 32'h00001008);
    tick();
    state("sim", 8'h20, 8'h08, 4'd6, 8'h04, 1'b0, 1'b0);

    // malformed alloc; valid free still goes through
    req(4'b0101, 4'b0001);
    comb("badA", 1'b0, 1'b1, 1'b1, 32'h0, 32'h00000020);
    tick();
    state("badA", 8'h40, 8'h08, 4'd5, 8'h04, 1'b0, 1'b0);

    // malformed free; valid alloc still goes through
    req(4'b0001, 4'b0010);
    comb("badF", 1'b1, 1'b0, 1'b1, 32'h00000008, 32'h0);
    tick();
    state("badF", 8'h40, 8'h10, 4'd6, 8'h08, 1'b0, 1'b0);

    // simultaneous accepted alloc and free
    req(4'b0011, 4'b0001);
    comb("both", 1'b1, 1'b1, 1'b0, 32'h00002010, 32'h00000040);
    tick();
    state("both", 8'h80, 8'h40, 4'd7, 8'h20, 1'b0, 1'b0);

    // free 0011 down to count 5, then reset between edges
    req(4'b0000, 4'b0011);
    tick();
    state("pre", 8'h02, 8'h40, 4'd5, 8'h20, 1'b0, 1'b0);
    req(4'b0000, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    state("midrst", 8'h01, 8'h01, 4'd0, 8'h00, 1'b0, 1'b1);
    reset = 1'b0;

    // empty: free rejected, alloc from slot 0
    req(4'b0001, 4'b0001);
    comb("post", 1'b1, 1'b0, 1'b0, 32'h00000001, 32'h0);
    tick();
    state("post", 8'h01, 8'h02, 4'd1, 8'h01, 1'b0, 1'b0);

    req(4'b0000, 4'b0000);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
